// File: rtl/cbdist.sv
// cbdist: four-way word distributor.
// A single producer hands over one word plus a destination mask; the word is
// copied into every selected output lane, and each lane drains through its
// own valid/ready pair. A word with an empty mask is counted and discarded.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no undelivered word; in_ready=1, next offered word is accepted
// SEND  | at least one lane still holds an undelivered word; in_ready=0
module cbdist #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic [3:0]   in_dest,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [7:0]   drop_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state;
  logic [3:0] still_pending;

  // Lanes that will still hold a word after this edge; all clear ends SEND.
  assign still_pending = out_valid & ~out_ready;

  // The producer may hand over a word only when no lane is pending.
  assign in_ready = (state == IDLE);

  // Handshake FSM, lane data registers, lane valids and the drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o0        <= '0;
      o1        <= '0;
      o2        <= '0;
      o3        <= '0;
      out_valid <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_dest != 4'b0000) begin
              // Unselected lanes keep their old contents.
              if (in_dest[0]) o0 <= in_data;
              if (in_dest[1]) o1 <= in_data;
              if (in_dest[2]) o2 <= in_data;
              if (in_dest[3]) o3 <= in_data;
              out_valid <= in_dest;
              state     <= SEND;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end
        SEND: begin
          // out_ready on an idle lane is masked by out_valid.
          out_valid <= still_pending;
          if (still_pending == 4'b0000) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbdist.sv
// Bench for cbdist: a negedge monitor pushes accepted words into per-lane
// scoreboard queues and pops/compares them when a lane handshake completes;
// directed steps check valids, ready, lane contents and the drop counter.
module tb_cbdist;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [3:0]   in_dest;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] o0, o1, o2, o3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [7:0]   drop_cnt;

  cbdist #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  logic [W-1:0] sbq [4][$];
  logic [W-1:0] exp_o [4];
  logic [7:0]   exp_drop;
  logic [W-1:0] o_arr [4];

  assign o_arr[0] = o0;
  assign o_arr[1] = o1;
  assign o_arr[2] = o2;
  assign o_arr[3] = o3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lanes(input string tag);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_o%0d", tag, k), 32'(o_arr[k]), 32'(exp_o[k]));
  endtask

  // Scoreboard: inputs are stable at negedge, so this sees exactly what the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        sbq[k].delete();
        exp_o[k] = '0;
      end
      exp_drop = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sbq[k].size() == 0)
            chk($sformatf("sb_pop_empty_%0d", k), 32'(sbq[k].size()), 32'd1);
          else
            chk($sformatf("sb_lane%0d", k), 32'(o_arr[k]), 32'(sbq[k].pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        if (in_dest == 4'b0000) begin
          if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (in_dest[k]) begin
              sbq[k].push_back(in_data);
              exp_o[k] = in_data;
            end
          end
        end
      end
    end
  end

  logic [3:0] seq_rdy [4];
  logic [3:0] seq_vld [4];
  int acc0;

  initial begin
    seq_rdy[0] = 4'b0001; seq_rdy[1] = 4'b0100; seq_rdy[2] = 4'b0010; seq_rdy[3] = 4'b1000;
    seq_vld[0] = 4'b1110; seq_vld[1] = 4'b1010; seq_vld[2] = 4'b1000; seq_vld[3] = 4'b0000;

    // 1: reset, checked before any clock edge (async)
    rst = 1'b1; in_data = '0; in_dest = '0; in_valid = 1'b0; out_ready = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_o0", 32'(o0), 32'd0);
    chk("rst_o3", 32'(o3), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 2: single lane, ready already asserted
    out_ready = 4'b1111; in_valid = 1'b1; in_dest = 4'b1000; in_data = 10'd140;
    tick();
    in_valid = 1'b0;
    chk("single_o3", 32'(o3), 32'd140);
    chk("single_valid", 32'(out_valid), 32'b1000);
    chk("single_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("single_valid_clr", 32'(out_valid), 32'd0);
    chk("single_ready1", 32'(in_ready), 32'd1);

    // 3: broadcast with staggered drain
    out_ready = 4'b0000; in_valid = 1'b1; in_dest = 4'b1111; in_data = 10'd15;
    tick();
    in_valid = 1'b0;
    chk("bc_valid", 32'(out_valid), 32'b1111);
    chk_lanes("bc");
    for (int i = 0; i < 4; i++) begin
      out_ready = seq_rdy[i];
      tick();
      chk($sformatf("bc_drain%0d", i), 32'(out_valid), 32'(seq_vld[i]));
      chk($sformatf("bc_ready%0d", i), 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
    end
    out_ready = 4'b0000;

    // 4: untouched lanes, held in_valid accepted once
    acc0 = n_acc;
    in_valid = 1'b1; in_dest = 4'b0010; in_data = 10'd12;
    tick();
    repeat (3) tick();
    chk("hold_valid", 32'(out_valid), 32'b0010);
    in_valid = 1'b0; out_ready = 4'b0010;
    tick();
    chk("hold_once", 32'(n_acc - acc0), 32'd1);
    out_ready = 4'b0000; in_valid = 1'b1; in_dest = 4'b0001; in_data = 10'd18;
    tick();
    chk("untouched_o1", 32'(o1), 32'd12);
    chk("untouched_o0", 32'(o0), 32'd18);
    chk_lanes("untouched");
    // last ready and a new offer in the same SEND cycle: no accept yet
    acc0 = n_acc;
    out_ready = 4'b0001; in_dest = 4'b0100; in_data = 10'd77;
    tick();
    chk("simul_ready", 32'(in_ready), 32'd1);
    chk("simul_valid", 32'(out_valid), 32'd0);
    chk("simul_noacc", 32'(n_acc - acc0), 32'd0);
    out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    chk("simul_late_valid", 32'(out_valid), 32'b0100);
    chk("simul_o2", 32'(o2), 32'd77);
    out_ready = 4'b1111;
    tick();
    chk("simul_drained", 32'(out_valid), 32'd0);

    // 5: drops and saturation
    in_valid = 1'b1; in_dest = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      in_data = 10'(100 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("drop3", 32'(drop_cnt), 32'd3);
    chk("drop3_model", 32'(drop_cnt), 32'(exp_drop));
    chk("drop3_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    repeat (257) tick();
    in_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    chk("drop_sat_model", 32'(drop_cnt), 32'(exp_drop));
    chk_lanes("after_drop");

    // 6: reset while lanes 0 and 2 are pending
    out_ready = 4'b0000; in_valid = 1'b1; in_dest = 4'b0101; in_data = 10'h155;
    tick();
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'b0101);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_o0", 32'(o0), 32'd0);
    chk("mid_rst_o1", 32'(o1), 32'd0);
    chk("mid_rst_o2", 32'(o2), 32'd0);
    chk("mid_rst_o3", 32'(o3), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);

    // function resumes after reset
    out_ready = 4'b1111; in_valid = 1'b1; in_dest = 4'b0110; in_data = 10'd5;
    tick();
    in_valid = 1'b0;
    chk("post_valid", 32'(out_valid), 32'b0110);
    chk_lanes("post");
    tick();
    chk("post_ready", 32'(in_ready), 32'd1);

    #10;
    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_left%0d", k), 32'(sbq[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
